// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch unit with a direct-mapped I-cache and a
// circular fetch queue feeding the dispatcher over a valid/ready handshake.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   rdy                      global ready; low freezes every register
//   pred_*/pc_to_pred_o/...  combinational branch-predictor lookup
//   mem_*                    single-word miss requests to MemCtrl
//   dsp_*                    queue head towards the dispatcher
//   flush_i/flush_pc_i       ROB mispredict redirect
//   fq_count_o               queue occupancy
//
// Optional feature: define NEXT_LINE_PREFETCH_EN to fetch fetch_pc+4 into
// the cache while the queue is full and fetch_pc hits.
//
// state  | meaning
// IDLE   | lookup at fetch_pc; enqueue on hit, request on miss
// MISS   | request outstanding; waiting for mem_ok_i to fill the cache
module ifetch_queue #(
  parameter int ADDR_W = 32,
  parameter int INS_W = 32,
  parameter int IC_ENTRIES = 16,
  parameter int FQ_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy,
  input  logic                          pred_jump_i,
  input  logic [ADDR_W-1:0]             pred_pc_i,
  output logic [ADDR_W-1:0]             pc_to_pred_o,
  output logic [INS_W-1:0]              code_to_pred_o,
  input  logic                          mem_ok_i,
  input  logic [INS_W-1:0]              mem_ins_i,
  output logic                          mem_en_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  input  logic                          dsp_ready_i,
  output logic                          dsp_valid_o,
  output logic [ADDR_W-1:0]             dsp_pc_o,
  output logic [INS_W-1:0]              dsp_ins_o,
  output logic                          dsp_pred_jump_o,
  output logic [ADDR_W-1:0]             dsp_pred_pc_o,
  input  logic                          flush_i,
  input  logic [ADDR_W-1:0]             flush_pc_i,
  output logic [$clog2(FQ_DEPTH):0]     fq_count_o
);

  localparam int IDX_W = $clog2(IC_ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MISS = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [IDX_W-1:0]  miss_idx;
  logic [TAG_W-1:0]  miss_tag;

  logic [IC_ENTRIES-1:0] ic_valid;
  logic [TAG_W-1:0]      ic_tag  [IC_ENTRIES];
  logic [INS_W-1:0]      ic_data [IC_ENTRIES];

  logic [ADDR_W-1:0] fq_pc   [FQ_DEPTH];
  logic [INS_W-1:0]  fq_ins  [FQ_DEPTH];
  logic              fq_pj   [FQ_DEPTH];
  logic [ADDR_W-1:0] fq_ppc  [FQ_DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;

  logic [IDX_W-1:0] fetch_idx;
  logic             hit, full, empty, push, pop, fill;

  assign fetch_idx = fetch_pc[IDX_W+1:2];
  assign hit = ic_valid[fetch_idx] && (ic_tag[fetch_idx] == fetch_pc[ADDR_W-1:IDX_W+2]);
  assign full = (count == CNT_W'(FQ_DEPTH));
  assign empty = (count == '0);

`ifdef NEXT_LINE_PREFETCH_EN
  logic [ADDR_W-1:0] next_pc;
  logic [IDX_W-1:0]  next_idx;
  logic              next_hit;
  assign next_pc = fetch_pc + ADDR_W'(4);
  assign next_idx = next_pc[IDX_W+1:2];
  assign next_hit = ic_valid[next_idx] && (ic_tag[next_idx] == next_pc[ADDR_W-1:IDX_W+2]);
`endif

  // A flush wins over everything queue-related, including a pop in the
  // same cycle; the cache fill is independent of flush.
  assign push = rdy && !flush_i && (state == S_IDLE) && hit && !full;
  assign pop = rdy && !flush_i && !empty && dsp_ready_i;
  assign fill = rdy && (state == S_MISS) && mem_ok_i;

  assign pc_to_pred_o = fetch_pc;
  assign code_to_pred_o = ic_data[fetch_idx];
  assign dsp_valid_o = !empty;
  assign dsp_pc_o = fq_pc[head];
  assign dsp_ins_o = fq_ins[head];
  assign dsp_pred_jump_o = fq_pj[head];
  assign dsp_pred_pc_o = fq_ppc[head];
  assign fq_count_o = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      fetch_pc <= RESET_PC;
      miss_idx <= '0;
      miss_tag <= '0;
      mem_en_o <= 1'b0;
      mem_addr_o <= '0;
      ic_valid <= '0;
      for (int i = 0; i < IC_ENTRIES; i++) begin
        ic_tag[i] <= '0;
        ic_data[i] <= '0;
      end
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (rdy) begin
      // Fill location comes from the captured miss address, so a redirect
      // while the request is outstanding still caches the right word.
      if (fill) begin
        ic_valid[miss_idx] <= 1'b1;
        ic_tag[miss_idx] <= miss_tag;
        ic_data[miss_idx] <= mem_ins_i;
        mem_en_o <= 1'b0;
        state <= S_IDLE;
      end

      if (flush_i) begin
        fetch_pc <= flush_pc_i;
      end else if (push) begin
        fetch_pc <= pred_pc_i;
      end else if (state == S_IDLE && !hit) begin
        mem_en_o <= 1'b1;
        mem_addr_o <= fetch_pc;
        miss_idx <= fetch_idx;
        miss_tag <= fetch_pc[ADDR_W-1:IDX_W+2];
        state <= S_MISS;
      end
`ifdef NEXT_LINE_PREFETCH_EN
      else if (state == S_IDLE && full && !next_hit) begin
        mem_en_o <= 1'b1;
        mem_addr_o <= next_pc;
        miss_idx <= next_idx;
        miss_tag <= next_pc[ADDR_W-1:IDX_W+2];
        state <= S_MISS;
      end
`endif

      if (flush_i) begin
        count <= '0;
        head <= tail;
      end else begin
        if (push) tail <= tail + PTR_W'(1);
        if (pop) head <= head + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Queue payload needs no reset: dsp_valid_o qualifies it.
  always_ff @(posedge clk) begin
    if (push) begin
      fq_pc[tail] <= fetch_pc;
      fq_ins[tail] <= ic_data[fetch_idx];
      fq_pj[tail] <= pred_jump_i;
      fq_ppc[tail] <= pred_pc_i;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        pred_jump_i;
  logic [31:0] pred_pc_i;
  logic [31:0] pc_to_pred_o;
  logic [31:0] code_to_pred_o;
  logic        mem_ok_i;
  logic [31:0] mem_ins_i;
  logic        mem_en_o;
  logic [31:0] mem_addr_o;
  logic        dsp_ready_i;
  logic        dsp_valid_o;
  logic [31:0] dsp_pc_o;
  logic [31:0] dsp_ins_o;
  logic        dsp_pred_jump_o;
  logic [31:0] dsp_pred_pc_o;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic [2:0]  fq_count_o;

  int checks = 0;
  int failures = 0;

  ifetch_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .pred_jump_i(pred_jump_i), .pred_pc_i(pred_pc_i),
    .pc_to_pred_o(pc_to_pred_o), .code_to_pred_o(code_to_pred_o),
    .mem_ok_i(mem_ok_i), .mem_ins_i(mem_ins_i),
    .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o),
    .dsp_ready_i(dsp_ready_i), .dsp_valid_o(dsp_valid_o),
    .dsp_pc_o(dsp_pc_o), .dsp_ins_o(dsp_ins_o),
    .dsp_pred_jump_o(dsp_pred_jump_o), .dsp_pred_pc_o(dsp_pred_pc_o),
    .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .fq_count_o(fq_count_o)
  );

  always #5 clk = ~clk;

  // Predictor: always falls through, flags only PC 0x8 as taken.
  assign pred_pc_i = pc_to_pred_o + 32'd4;
  assign pred_jump_i = (pc_to_pred_o == 32'h8);

  function automatic logic [31:0] ins_of(input logic [31:0] addr);
    return {addr[23:0], 8'h13};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ok(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (mem_ok_i) seen = 1'b1;
    end
    chk(tag, {31'b0, seen}, 32'd1);
  endtask

  task automatic wait_count(input string tag, input logic [2:0] n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      if (fq_count_o == n) seen = 1'b1;
    end
    chk(tag, {31'b0, seen}, 32'd1);
  endtask

  // MemCtrl model: answers a held request MEM_LAT cycles later with a
  // one-cycle pulse; repeats while the request stays up (e.g. rdy low).
  initial begin
    mem_ok_i = 1'b0;
    mem_ins_i = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst && mem_en_o) begin
        repeat (MEM_LAT) @(posedge clk);
        #2;
        mem_ok_i = 1'b1;
        mem_ins_i = ins_of(mem_addr_o);
        @(posedge clk);
        #2;
        mem_ok_i = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    rst = 1'b0;
    rdy = 1'b1;
    dsp_ready_i = 1'b0;
    flush_i = 1'b0;
    flush_pc_i = '0;
    repeat (3) tick();

    chk("rst_pc", pc_to_pred_o, 32'h0);
    chk("rst_code", code_to_pred_o, 32'h0);
    chk("rst_mem_en", {31'b0, mem_en_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_valid", {31'b0, dsp_valid_o}, 32'd0);
    chk("rst_count", {29'b0, fq_count_o}, 32'd0);

    // Cold start: first lookup misses and requests address 0.
    rst = 1'b1;
    tick();
    chk("cold_mem_en", {31'b0, mem_en_o}, 32'd1);
    chk("cold_mem_addr", mem_addr_o, 32'h0);
    wait_ok("cold_ok");
    chk("fill_mem_en_drop", {31'b0, mem_en_o}, 32'd0);
    chk("fill_no_enq_yet", {31'b0, dsp_valid_o}, 32'd0);
    tick();
    chk("first_valid", {31'b0, dsp_valid_o}, 32'd1);
    chk("first_pc", dsp_pc_o, 32'h0);
    chk("first_ins", dsp_ins_o, 32'h13);
    chk("first_count", {29'b0, fq_count_o}, 32'd1);
    chk("first_pred_pc", dsp_pred_pc_o, 32'h4);

    // Warm 0x0-0x1C while draining.
    dsp_ready_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      if (pc_to_pred_o == 32'h20) seen = 1'b1;
    end
    chk("warm_reach_20", {31'b0, seen}, 32'd1);

    // Restart at 0 with the dispatcher stalled: four hits fill the queue.
    dsp_ready_i = 1'b0;
    flush_i = 1'b1;
    flush_pc_i = 32'h0;
    tick();
    flush_i = 1'b0;
    chk("restart_count", {29'b0, fq_count_o}, 32'd0);
    chk("restart_valid", {31'b0, dsp_valid_o}, 32'd0);
    repeat (4) tick();
    chk("stream_count4", {29'b0, fq_count_o}, 32'd4);
    chk("stream_pc10", pc_to_pred_o, 32'h10);
    repeat (2) tick();
    chk("full_hold_count", {29'b0, fq_count_o}, 32'd4);
    chk("full_hold_pc", pc_to_pred_o, 32'h10);
    chk("full_no_req", {31'b0, mem_en_o}, 32'd0);
    chk("full_head_pc", dsp_pc_o, 32'h0);
    chk("full_head_ins", dsp_ins_o, 32'h13);

    // Release: first cycle pops only (push blocked while full), then 1:1.
    dsp_ready_i = 1'b1;
    tick();
    chk("pop1_count", {29'b0, fq_count_o}, 32'd3);
    chk("pop1_head", dsp_pc_o, 32'h4);
    tick();
    chk("pp2_count", {29'b0, fq_count_o}, 32'd3);
    chk("pp2_head", dsp_pc_o, 32'h8);
    chk("pp2_pred_jump", {31'b0, dsp_pred_jump_o}, 32'd1);
    chk("pp2_pred_pc", dsp_pred_pc_o, 32'hC);
    tick();
    chk("pp3_count", {29'b0, fq_count_o}, 32'd3);
    chk("pp3_head", dsp_pc_o, 32'hC);
    chk("pp3_pred_jump", {31'b0, dsp_pred_jump_o}, 32'd0);
    chk("pp3_fetch_pc", pc_to_pred_o, 32'h18);

    // Flush with 3 entries and a pop pending.
    flush_i = 1'b1;
    flush_pc_i = 32'h100;
    tick();
    chk("flush_count", {29'b0, fq_count_o}, 32'd0);
    chk("flush_valid", {31'b0, dsp_valid_o}, 32'd0);
    chk("flush_pc", pc_to_pred_o, 32'h100);

    // Miss on 0x40 (aliases 0x0), then redirect to 0x80 while outstanding.
    flush_pc_i = 32'h40;
    dsp_ready_i = 1'b0;
    tick();
    flush_i = 1'b0;
    chk("redir40_pc", pc_to_pred_o, 32'h40);
    tick();
    chk("miss40_en", {31'b0, mem_en_o}, 32'd1);
    chk("miss40_addr", mem_addr_o, 32'h40);
    flush_i = 1'b1;
    flush_pc_i = 32'h80;
    tick();
    flush_i = 1'b0;
    chk("missflush_en_held", {31'b0, mem_en_o}, 32'd1);
    chk("missflush_addr", mem_addr_o, 32'h40);
    chk("missflush_pc", pc_to_pred_o, 32'h80);
    chk("missflush_count", {29'b0, fq_count_o}, 32'd0);
    wait_ok("miss40_ok");
    chk("miss40_en_drop", {31'b0, mem_en_o}, 32'd0);
    chk("miss40_no_enq", {29'b0, fq_count_o}, 32'd0);

    // 0x40 must now hit without a request.
    flush_i = 1'b1;
    flush_pc_i = 32'h40;
    tick();
    flush_i = 1'b0;
    chk("back40_no_req", {31'b0, mem_en_o}, 32'd0);
    tick();
    chk("hit40_count", {29'b0, fq_count_o}, 32'd1);
    chk("hit40_pc", dsp_pc_o, 32'h40);
    chk("hit40_ins", dsp_ins_o, 32'h4013);
    chk("hit40_no_req", {31'b0, mem_en_o}, 32'd0);

    // 0x0 was evicted by 0x40: must miss again.
    flush_i = 1'b1;
    flush_pc_i = 32'h0;
    tick();
    flush_i = 1'b0;
    tick();
    chk("alias_en", {31'b0, mem_en_o}, 32'd1);
    chk("alias_addr", mem_addr_o, 32'h0);

    // rdy low: nothing moves, flush and mem_ok are ignored.
    rdy = 1'b0;
    flush_i = 1'b1;
    flush_pc_i = 32'h200;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("frz_count", {29'b0, fq_count_o}, 32'd0);
      chk("frz_en", {31'b0, mem_en_o}, 32'd1);
      chk("frz_addr", mem_addr_o, 32'h0);
      chk("frz_pc", pc_to_pred_o, 32'h0);
    end
    rdy = 1'b1;
    flush_i = 1'b0;
    wait_ok("thaw_ok");
    chk("thaw_en_drop", {31'b0, mem_en_o}, 32'd0);
    tick();
    chk("thaw_count", {29'b0, fq_count_o}, 32'd1);
    chk("thaw_head", dsp_pc_o, 32'h0);
    chk("thaw_ins", dsp_ins_o, 32'h13);

    // Fill the queue from a cold region; fetch_pc ends at 0x210.
    flush_i = 1'b1;
    flush_pc_i = 32'h200;
    tick();
    flush_i = 1'b0;
    chk("cold_region_count", {29'b0, fq_count_o}, 32'd0);
    wait_count("cold_region_full", 3'd4);
    chk("cold_region_pc", pc_to_pred_o, 32'h210);
    tick();
    chk("full_miss_en", {31'b0, mem_en_o}, 32'd1);
    chk("full_miss_addr", mem_addr_o, 32'h210);
    wait_ok("full_miss_ok");
    tick();
    chk("full_hit_count", {29'b0, fq_count_o}, 32'd4);
    chk("full_hit_pc", pc_to_pred_o, 32'h210);
`ifdef NEXT_LINE_PREFETCH_EN
    chk("prefetch_en", {31'b0, mem_en_o}, 32'd1);
    chk("prefetch_addr", mem_addr_o, 32'h214);
`else
    chk("stall_no_req", {31'b0, mem_en_o}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
